// File: rtl/router_pkg.sv
// Shared types, constants and header field helpers for the router
// packet register: FSM states, check-mode codes, addr/len extraction.
package router_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DRAIN
    } state_t;

    localparam int CHK_XOR = 0;
    localparam int CHK_SUM = 1;

    // Header fields are extracted on a 32-bit view; callers cast to width.
    function automatic logic [31:0] hdr_addr(
        input logic [31:0] hdr,
        input int          addr_w
    );
        return hdr & ((32'd1 << addr_w) - 32'd1);
    endfunction

    function automatic logic [31:0] hdr_len(
        input logic [31:0] hdr,
        input int          addr_w
    );
        return hdr >> addr_w;
    endfunction

endpackage

// File: rtl/router_hold_fifo.sv
// Small hold buffer that absorbs bytes while the destination FIFO is full.
// Ports: clock, reset, push/din, pop/head, full, empty.
module router_hold_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/router_pkt_reg.sv
// Router input packet register: forwards header/payload/check bytes to
// the destination FIFO, checks parity/checksum and header length.
// Ports: clock/reset, source side (in_valid, pkt_valid, data_in,
// in_ready), FIFO side (fifo_full, dout, dout_valid), status outputs
// (pkt_addr, addr_valid, parity_done, low_pkt_valid, err, len_err).
module router_pkt_reg
    import router_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 2,
    parameter int HOLD_DEPTH = 2,
    parameter int CHK_MODE   = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              in_ready,
    input  logic              fifo_full,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [ADDR_W-1:0] pkt_addr,
    output logic              addr_valid,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err,
    output logic              len_err
);

    localparam int LEN_W = DATA_W - ADDR_W;

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic [DATA_W-1:0] chk;
    logic [DATA_W-1:0] chk_next;
    logic [DATA_W-1:0] chk_byte;
    logic [DATA_W-1:0] hold_head;
    logic              hold_full;
    logic              hold_empty;
    logic              accept;
    logic              fwd;
    logic              direct;
    logic              push;
    logic              pop;

    assign in_ready = ((state == S_IDLE) || (state == S_LOAD)) && !hold_full;
    assign accept   = in_valid & in_ready;
    // Dropped IDLE bytes (pkt_valid=0) are never forwarded.
    assign fwd      = accept & (pkt_valid | (state == S_LOAD));
    // Bypass only when nothing is queued, so byte order is preserved.
    assign direct   = fwd & hold_empty & ~fifo_full;
    assign push     = fwd & ~direct;
    assign pop      = ~hold_empty & ~fifo_full;
    assign chk_next = (CHK_MODE == CHK_SUM) ? chk + data_in : chk ^ data_in;

    router_hold_fifo #(
        .W     (DATA_W),
        .DEPTH (HOLD_DEPTH)
    ) u_hold (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (data_in),
        .pop   (pop),
        .head  (hold_head),
        .full  (hold_full),
        .empty (hold_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            dout          <= '0;
            dout_valid    <= 1'b0;
            pkt_addr      <= '0;
            addr_valid    <= 1'b0;
            parity_done   <= 1'b0;
            low_pkt_valid <= 1'b0;
            err           <= 1'b0;
            len_err       <= 1'b0;
            len_q         <= '0;
            cnt           <= '0;
            chk           <= '0;
            chk_byte      <= '0;
        end else begin
            dout_valid  <= 1'b0;
            parity_done <= 1'b0;

            if (pop) begin
                dout       <= hold_head;
                dout_valid <= 1'b1;
            end else if (direct) begin
                dout       <= data_in;
                dout_valid <= 1'b1;
            end

            // A check-byte set below overrides this clear.
            if (rst_int_reg) low_pkt_valid <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (accept && pkt_valid) begin
                        pkt_addr   <= ADDR_W'(hdr_addr(32'(data_in), ADDR_W));
                        len_q      <= LEN_W'(hdr_len(32'(data_in), ADDR_W));
                        chk        <= data_in;
                        cnt        <= '0;
                        err        <= 1'b0;
                        len_err    <= 1'b0;
                        addr_valid <= 1'b1;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept && pkt_valid) begin
                        chk <= chk_next;
                        if (cnt != '1) cnt <= cnt + LEN_W'(1);
                    end else if (accept) begin
                        chk_byte      <= data_in;
                        low_pkt_valid <= 1'b1;
                        parity_done   <= 1'b1;
                        state         <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    err     <= (chk != chk_byte);
                    len_err <= (cnt != len_q);
                    if (hold_empty) begin
                        state      <= S_IDLE;
                        addr_valid <= 1'b0;
                    end else begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (hold_empty) begin
                        state      <= S_IDLE;
                        addr_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_reg.sv
// Directed self-checking bench for router_pkt_reg (XOR and SUM instances
// driven by the same stimulus).
module tb_router_pkt_reg;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       rst_int_reg;

    logic       in_ready0, dout_valid0, addr_valid0, parity_done0;
    logic       low0, err0, len_err0;
    logic [7:0] dout0;
    logic [1:0] pkt_addr0;

    logic       in_ready1, dout_valid1, addr_valid1, parity_done1;
    logic       low1, err1, len_err1;
    logic [7:0] dout1;
    logic [1:0] pkt_addr1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    router_pkt_reg #(.CHK_MODE(0)) dut0 (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .in_ready      (in_ready0),
        .fifo_full     (fifo_full),
        .rst_int_reg   (rst_int_reg),
        .dout          (dout0),
        .dout_valid    (dout_valid0),
        .pkt_addr      (pkt_addr0),
        .addr_valid    (addr_valid0),
        .parity_done   (parity_done0),
        .low_pkt_valid (low0),
        .err           (err0),
        .len_err       (len_err0)
    );

    router_pkt_reg #(.CHK_MODE(1)) dut1 (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .in_ready      (in_ready1),
        .fifo_full     (fifo_full),
        .rst_int_reg   (rst_int_reg),
        .dout          (dout1),
        .dout_valid    (dout_valid1),
        .pkt_addr      (pkt_addr1),
        .addr_valid    (addr_valid1),
        .parity_done   (parity_done1),
        .low_pkt_valid (low1),
        .err           (err1),
        .len_err       (len_err1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic pv, input logic [7:0] b);
        in_valid  = 1'b1;
        pkt_valid = pv;
        data_in   = b;
        tick();
        in_valid  = 1'b0;
        pkt_valid = 1'b0;
    endtask

    // Byte must be accepted and appear on dout one cycle later.
    task automatic send_fwd(input string tag, input logic pv,
                            input logic [7:0] b);
        check({tag, "_rdy"}, 32'(in_ready0), 32'd1);
        send(pv, b);
        check({tag, "_dout"}, {23'd0, dout_valid0, dout0}, {23'd0, 1'b1, b});
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        pkt_valid   = 1'b0;
        data_in     = 8'h00;
        fifo_full   = 1'b0;
        rst_int_reg = 1'b0;
        tick();
        check("rst_rdy", 32'(in_ready0), 32'd1);
        check("rst_outs", {dout0, dout_valid0, pkt_addr0, addr_valid0,
              parity_done0, low0, err0, len_err0}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: good packet
        send_fwd("t1_hdr", 1'b1, 8'h0D);
        check("t1_addr", {addr_valid0, pkt_addr0}, 32'b101);
        send_fwd("t1_p0", 1'b1, 8'h11);
        send_fwd("t1_p1", 1'b1, 8'h22);
        send_fwd("t1_p2", 1'b1, 8'h33);
        send_fwd("t1_ck", 1'b0, 8'h0D);
        check("t1_pd", {parity_done0, low0, in_ready0}, 32'b110);
        tick();
        check("t1_res", {parity_done0, err0, len_err0, addr_valid0,
              in_ready0}, 32'b00001);
        rst_int_reg = 1'b1;
        tick();
        rst_int_reg = 1'b0;
        check("t1_low_clr", 32'(low0), 32'd0);

        // 2: bad check byte
        send_fwd("t2_hdr", 1'b1, 8'h0D);
        send_fwd("t2_p0", 1'b1, 8'h11);
        send_fwd("t2_p1", 1'b1, 8'h22);
        send_fwd("t2_p2", 1'b1, 8'h33);
        send_fwd("t2_ck", 1'b0, 8'h0E);
        tick();
        check("t2_err", {err0, len_err0}, 32'b10);
        tick();
        tick();
        check("t2_hold", 32'(err0), 32'd1);

        // 3: short payload
        send_fwd("t3_hdr", 1'b1, 8'h0D);
        check("t3_clr", {err0, len_err0}, 32'b00);
        send_fwd("t3_p0", 1'b1, 8'h11);
        send_fwd("t3_p1", 1'b1, 8'h22);
        send_fwd("t3_ck", 1'b0, 8'h3E);
        tick();
        check("t3_res", {err0, len_err0}, 32'b01);

        // 4: FIFO full during payload
        send_fwd("t4_hdr", 1'b1, 8'h0D);
        send_fwd("t4_p0", 1'b1, 8'h11);
        fifo_full = 1'b1;
        check("t4_rdy1", 32'(in_ready0), 32'd1);
        send(1'b1, 8'h22);
        check("t4_q1", {dout_valid0, in_ready0}, 32'b01);
        send(1'b1, 8'h33);
        check("t4_q2", {dout_valid0, in_ready0}, 32'b00);
        tick();
        tick();
        check("t4_stall", {dout_valid0, in_ready0}, 32'b00);
        fifo_full = 1'b0;
        tick();
        check("t4_pop0", {dout_valid0, dout0}, {23'd0, 1'b1, 8'h22});
        tick();
        check("t4_pop1", {dout_valid0, dout0, in_ready0},
              {22'd0, 1'b1, 8'h33, 1'b1});
        send_fwd("t4_ck", 1'b0, 8'h0D);
        tick();
        check("t4_res", {err0, len_err0, dout_valid0}, 32'b000);

        // 5: additive checksum instance
        send(1'b1, 8'h09);
        send(1'b1, 8'hF0);
        send(1'b1, 8'h20);
        send(1'b0, 8'h19);
        tick();
        check("t5_sum_ok", {err1, len_err1, pkt_addr1}, 32'b0001);
        send(1'b1, 8'h09);
        send(1'b1, 8'hF0);
        send(1'b1, 8'h20);
        send(1'b0, 8'h18);
        tick();
        check("t5_sum_bad", {err1, len_err1}, 32'b10);
        check("t5_xor_bad", 32'(err0), 32'd1);

        // 6: reset mid-packet with a held byte
        send_fwd("t6_hdr", 1'b1, 8'h0D);
        fifo_full = 1'b1;
        send(1'b1, 8'h11);
        check("t6_held", {dout_valid0, in_ready0, low0}, 32'b011);
        reset     = 1'b1;
        fifo_full = 1'b0;
        tick();
        reset = 1'b0;
        check("t6_rst_rdy", 32'(in_ready0), 32'd1);
        check("t6_rst_outs", {dout0, dout_valid0, pkt_addr0, addr_valid0,
              parity_done0, low0, err0, len_err0}, 32'd0);
        tick();
        check("t6_nowr0", 32'(dout_valid0), 32'd0);
        tick();
        check("t6_nowr1", 32'(dout_valid0), 32'd0);

        // zero-length packet, rst_int_reg coincident with check byte
        send_fwd("t6_zhdr", 1'b1, 8'h01);
        rst_int_reg = 1'b1;
        send_fwd("t6_zck", 1'b0, 8'h01);
        rst_int_reg = 1'b0;
        check("t6_low_set", {low0, parity_done0}, 32'b11);
        tick();
        check("t6_zres", {err0, len_err0, low0}, 32'b001);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
